// File: rtl/fp_round_pack_pkg.sv
// Shared floating-point format constants, flag layout and special-value
// constructors for the MAC output path (default single-precision format).
package fp_round_pack_pkg;

  localparam int FP_DATA_W  = 32;
  localparam int FP_EXP_W   = 8;
  localparam int FP_F_W     = FP_DATA_W - FP_EXP_W - 1;
  localparam int FP_MAN_W   = FP_F_W + 1;
  localparam int FP_BIAS    = (1 << (FP_EXP_W - 1)) - 1;
  localparam int FP_EXP_INF = (1 << FP_EXP_W) - 1;

  // Bit positions inside the 4-bit exception flag vector
  localparam int FLAG_W         = 4;
  localparam int FLAG_INVALID   = 3;
  localparam int FLAG_OVERFLOW  = 2;
  localparam int FLAG_UNDERFLOW = 1;
  localparam int FLAG_INEXACT   = 0;

  // Signed infinity in the default format
  function automatic logic [FP_DATA_W-1:0] fp_inf(input logic sign);
    return {sign, {FP_EXP_W{1'b1}}, {FP_F_W{1'b0}}};
  endfunction

  // Canonical quiet NaN in the default format (positive, top fraction bit set)
  function automatic logic [FP_DATA_W-1:0] fp_nan();
    return {1'b0, {FP_EXP_W{1'b1}}, 1'b1, {(FP_F_W-1){1'b0}}};
  endfunction

endpackage

// File: rtl/fp_round_pack_rne_incr.sv
// Round-to-nearest-even decision on {mantissa, G, R, S} plus the mantissa
// increment; the sum is one bit wider so a carry-out stays visible.
module fp_rne_incr
  import fp_round_pack_pkg::*;
#(
  parameter int MAN_W = FP_MAN_W
) (
  input  logic [MAN_W+2:0] man,
  output logic [MAN_W:0]   sum,
  output logic             inexact
);

  logic lsb, g, r, s, inc;

  // Round up on more-than-half, or exactly half when the kept LSB is odd
  always_comb begin
    lsb     = man[3];
    g       = man[2];
    r       = man[1];
    s       = man[0];
    inc     = g & (r | s | lsb);
    inexact = g | r | s;
    sum     = {1'b0, man[MAN_W+2:3]} + {{MAN_W{1'b0}}, inc};
  end

endmodule

// File: rtl/fp_round_pack.sv
// Two-stage round-and-pack pipeline: stage 1 rounds, stage 2 resolves
// carry-out, subnormal promotion, overflow and NaN and registers the packed
// word with its exception flags. Full valid/ready backpressure.
module fp_round_pack
  import fp_round_pack_pkg::*;
#(
  parameter int DATA_W = FP_DATA_W,
  parameter int EXP_W  = FP_EXP_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_sign,
  input  logic [EXP_W+1:0]          in_exp,
  input  logic [DATA_W-EXP_W+2:0]   in_man,
  input  logic                      in_nan,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W-1:0]         out_data,
  output logic [FLAG_W-1:0]         out_flags,
  output logic [FLAG_W-1:0]         sticky_flags,
  input  logic                      flags_clr
);

  localparam int F_W   = DATA_W - EXP_W - 1;
  localparam int MAN_W = F_W + 1;
  localparam int XW    = EXP_W + 2;
  localparam int RW    = EXP_W + 3;   // room for exp + carry without wrap
  localparam logic [RW-1:0]     EXP_INF_R = {3'b000, {EXP_W{1'b1}}};
  localparam logic [DATA_W-1:0] NAN_WORD  = {1'b0, {EXP_W{1'b1}}, 1'b1, {(F_W-1){1'b0}}};

  // Stage 1 registers
  logic             s1_valid_q, s1_valid_d;
  logic             s1_sign_q, s1_sign_d;
  logic [XW-1:0]    s1_exp_q, s1_exp_d;
  logic [MAN_W:0]   s1_sum_q, s1_sum_d;
  logic             s1_inexact_q, s1_inexact_d;
  logic             s1_nan_q, s1_nan_d;
  // Stage 2 / output registers
  logic             s2_valid_q, s2_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [FLAG_W-1:0] out_flags_q, out_flags_d;
  logic [FLAG_W-1:0] sticky_q, sticky_d;

  logic             rne_inexact;
  logic [MAN_W:0]   rne_sum;

  logic             s1_load, s2_ready, s2_load, out_hs;
  logic             carry, ovf;
  logic [RW-1:0]    exp_r;
  logic [EXP_W-1:0] exp_field;
  logic [F_W-1:0]   frac;
  logic [DATA_W-1:0] pack_word;
  logic [FLAG_W-1:0] pack_flags;

  fp_rne_incr #(.MAN_W(MAN_W)) u_rne (
    .man     (in_man),
    .sum     (rne_sum),
    .inexact (rne_inexact)
  );

  // Stage 2 datapath: carry/subnormal/overflow/NaN resolution and packing
  always_comb begin
    carry = s1_sum_q[MAN_W];
    exp_r = {1'b0, s1_exp_q} + {{(RW-1){1'b0}}, carry};
    frac  = carry ? s1_sum_q[MAN_W-1:1] : s1_sum_q[F_W-1:0];
    // A zero biased exponent only becomes 1 if rounding set the integer bit
    if (s1_sum_q == '0)
      exp_field = '0;
    else if (exp_r == '0)
      exp_field = {{(EXP_W-1){1'b0}}, s1_sum_q[MAN_W-1]};
    else
      exp_field = exp_r[EXP_W-1:0];
    ovf        = (exp_r >= EXP_INF_R);
    pack_word  = {s1_sign_q, exp_field, frac};
    pack_flags = '0;
    if (s1_nan_q) begin
      pack_word                 = NAN_WORD;
      pack_flags[FLAG_INVALID]  = 1'b1;
    end else if (ovf) begin
      pack_word                 = {s1_sign_q, {EXP_W{1'b1}}, {F_W{1'b0}}};
      pack_flags[FLAG_OVERFLOW] = 1'b1;
      pack_flags[FLAG_INEXACT]  = 1'b1;
    end else begin
      pack_flags[FLAG_UNDERFLOW] = (exp_field == '0) & s1_inexact_q;
      pack_flags[FLAG_INEXACT]   = s1_inexact_q;
    end
  end

  // Pipeline handshake control and next-state selection for all registers
  always_comb begin
    s2_ready   = ~s2_valid_q | out_ready;
    in_ready   = ~s1_valid_q | ~s2_valid_q | out_ready;
    s1_load    = in_valid & in_ready;
    s2_load    = s2_ready & s1_valid_q;
    out_hs     = s2_valid_q & out_ready;

    s1_valid_d   = in_ready ? in_valid : s1_valid_q;
    s1_sign_d    = s1_load ? in_sign     : s1_sign_q;
    s1_exp_d     = s1_load ? in_exp      : s1_exp_q;
    s1_sum_d     = s1_load ? rne_sum     : s1_sum_q;
    s1_inexact_d = s1_load ? rne_inexact : s1_inexact_q;
    s1_nan_d     = s1_load ? in_nan      : s1_nan_q;

    s2_valid_d  = s2_ready ? s1_valid_q : s2_valid_q;
    out_data_d  = s2_load ? pack_word  : out_data_q;
    out_flags_d = s2_load ? pack_flags : out_flags_q;

    // Clear first, then accumulate the flags of the result leaving now
    sticky_d = (flags_clr ? '0 : sticky_q) | (out_hs ? out_flags_q : '0);
  end

  // State registers with synchronous reset dropping any in-flight results
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q   <= 1'b0;
      s1_sign_q    <= 1'b0;
      s1_exp_q     <= '0;
      s1_sum_q     <= '0;
      s1_inexact_q <= 1'b0;
      s1_nan_q     <= 1'b0;
      s2_valid_q   <= 1'b0;
      out_data_q   <= '0;
      out_flags_q  <= '0;
      sticky_q     <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_sign_q    <= s1_sign_d;
      s1_exp_q     <= s1_exp_d;
      s1_sum_q     <= s1_sum_d;
      s1_inexact_q <= s1_inexact_d;
      s1_nan_q     <= s1_nan_d;
      s2_valid_q   <= s2_valid_d;
      out_data_q   <= out_data_d;
      out_flags_q  <= out_flags_d;
      sticky_q     <= sticky_d;
    end
  end

  assign out_valid    = s2_valid_q;
  assign out_data     = out_data_q;
  assign out_flags    = out_flags_q;
  assign sticky_flags = sticky_q;

endmodule

// File: tb/tb_fp_round_pack.sv
// Directed vector bench for fp_round_pack (32-bit word, 8-bit exponent).
module tb_fp_round_pack;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [9:0]  in_exp;
  logic [26:0] in_man;
  logic        in_nan;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [3:0]  out_flags;
  logic [3:0]  sticky_flags;
  logic        flags_clr;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        sign;
    logic [9:0]  exp;
    logic [26:0] man;
    logic        nan;
    logic [31:0] data;
    logic [3:0]  flags;
  } vec_t;

  vec_t vecs[13];
  vec_t bp[4];

  fp_round_pack dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_sign      (in_sign),
    .in_exp       (in_exp),
    .in_man       (in_man),
    .in_nan       (in_nan),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_flags    (out_flags),
    .sticky_flags (sticky_flags),
    .flags_clr    (flags_clr)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [26:0] mk(input logic i, input logic [22:0] f, input logic [2:0] grs);
    return {i, f, grs};
  endfunction

  function automatic vec_t mkv(input logic sg, input logic [9:0] e, input logic [26:0] m,
                               input logic n, input logic [31:0] d, input logic [3:0] fl);
    vec_t v;
    v.sign = sg; v.exp = e; v.man = m; v.nan = n; v.data = d; v.flags = fl;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%08h", name, act);
    end
  endtask

  task automatic drive(input vec_t v);
    in_sign = v.sign;
    in_exp  = v.exp;
    in_man  = v.man;
    in_nan  = v.nan;
  endtask

  initial begin
    int cyc;
    int idx;
    int got;
    logic rdy;
    logic clr_now;

    vecs[0]  = mkv(1'b0, 10'd127, mk(1'b1, 23'h000000, 3'b000), 1'b0, 32'h3F800000, 4'b0000);
    vecs[1]  = mkv(1'b0, 10'd127, mk(1'b1, 23'h000001, 3'b100), 1'b0, 32'h3F800002, 4'b0001);
    vecs[2]  = mkv(1'b0, 10'd127, mk(1'b1, 23'h000000, 3'b100), 1'b0, 32'h3F800000, 4'b0001);
    vecs[3]  = mkv(1'b0, 10'd127, mk(1'b1, 23'h7FFFFF, 3'b110), 1'b0, 32'h40000000, 4'b0001);
    vecs[4]  = mkv(1'b0, 10'd254, mk(1'b1, 23'h7FFFFF, 3'b110), 1'b0, 32'h7F800000, 4'b0101);
    vecs[5]  = mkv(1'b1, 10'd300, mk(1'b1, 23'h000000, 3'b000), 1'b0, 32'hFF800000, 4'b0101);
    vecs[6]  = mkv(1'b1, 10'd127, mk(1'b1, 23'h012345, 3'b111), 1'b1, 32'h7FC00000, 4'b1000);
    vecs[7]  = mkv(1'b0, 10'd0,   mk(1'b0, 23'h7FFFFF, 3'b100), 1'b0, 32'h00800000, 4'b0001);
    vecs[8]  = mkv(1'b0, 10'd0,   mk(1'b0, 23'h000001, 3'b001), 1'b0, 32'h00000001, 4'b0011);
    vecs[9]  = mkv(1'b1, 10'd0,   mk(1'b0, 23'h000000, 3'b000), 1'b0, 32'h80000000, 4'b0000);
    vecs[10] = mkv(1'b0, 10'd127, mk(1'b1, 23'h000000, 3'b101), 1'b0, 32'h3F800001, 4'b0001);
    vecs[11] = mkv(1'b0, 10'd127, mk(1'b1, 23'h000000, 3'b011), 1'b0, 32'h3F800000, 4'b0001);
    vecs[12] = mkv(1'b0, 10'd253, mk(1'b1, 23'h7FFFFF, 3'b000), 1'b0, 32'h7EFFFFFF, 4'b0000);

    bp[0] = mkv(1'b0, 10'd254, mk(1'b1, 23'h7FFFFF, 3'b110), 1'b0, 32'h7F800000, 4'b0101);
    bp[1] = mkv(1'b0, 10'd127, mk(1'b1, 23'h000000, 3'b000), 1'b0, 32'h3F800000, 4'b0000);
    bp[2] = mkv(1'b0, 10'd128, mk(1'b1, 23'h000000, 3'b000), 1'b0, 32'h40000000, 4'b0000);
    bp[3] = mkv(1'b0, 10'd0,   mk(1'b0, 23'h000001, 3'b001), 1'b0, 32'h00000001, 4'b0011);

    // Reset
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; flags_clr = 1'b0;
    in_sign = 1'b0; in_exp = '0; in_man = '0; in_nan = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_out_flags", 32'(out_flags), 32'd0);
    chk("rst_sticky", 32'(sticky_flags), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Table-driven single transactions with out_ready held high
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      drive(vecs[i]);
      in_valid = 1'b1;
      chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
      chk($sformatf("v%0d_early_valid", i), 32'(out_valid), 32'd0);
      cyc = 1;
      while (!out_valid && cyc < 8) begin
        @(negedge clk);
        cyc++;
      end
      chk($sformatf("v%0d_latency", i), 32'(cyc), 32'd2);
      chk($sformatf("v%0d_data", i), out_data, vecs[i].data);
      chk($sformatf("v%0d_flags", i), 32'(out_flags), 32'(vecs[i].flags));
    end
    @(negedge clk);
    chk("table_idle", 32'(out_valid), 32'd0);
    chk("table_sticky", 32'(sticky_flags), 32'hF);
    flags_clr = 1'b1;
    @(negedge clk);
    flags_clr = 1'b0;
    chk("sticky_cleared", 32'(sticky_flags), 32'd0);

    // Backpressure: fill with out_ready low, output must hold
    out_ready = 1'b0;
    drive(bp[0]);
    in_valid = 1'b1;
    idx = 0;
    #1;
    for (int c = 0; c < 6; c++) begin
      rdy = in_ready;
      if (out_valid) begin
        chk($sformatf("bp_hold_data_c%0d", c), out_data, bp[0].data);
        chk($sformatf("bp_hold_flags_c%0d", c), 32'(out_flags), 32'(bp[0].flags));
      end
      @(negedge clk);
      if (rdy) begin
        idx++;
        if (idx < 4) drive(bp[idx]);
        else in_valid = 1'b0;
      end
    end
    chk("bp_accepted", 32'(idx), 32'd2);
    chk("bp_in_ready_low", 32'(in_ready), 32'd0);
    chk("bp_out_valid", 32'(out_valid), 32'd1);

    // Drain: all four emitted in order; flags_clr with the last handshake
    out_ready = 1'b1;
    #1;
    got = 0;
    for (int c = 0; c < 20; c++) begin
      if (got < 4) begin
        rdy = in_ready;
        clr_now = 1'b0;
        if (out_valid) begin
          chk($sformatf("bp_out%0d_data", got), out_data, bp[got].data);
          chk($sformatf("bp_out%0d_flags", got), 32'(out_flags), 32'(bp[got].flags));
          if (got == 3) begin
            chk("bp_sticky_before_clr", 32'(sticky_flags), 32'b0101);
            flags_clr = 1'b1;
            clr_now = 1'b1;
          end
          got++;
        end
        @(negedge clk);
        flags_clr = 1'b0;
        if (rdy && in_valid) begin
          idx++;
          if (idx < 4) drive(bp[idx]);
          else in_valid = 1'b0;
        end
        if (clr_now) chk("bp_sticky_clr_and_set", 32'(sticky_flags), 32'b0011);
      end
    end
    chk("bp_count", 32'(got), 32'd4);
    chk("bp_all_accepted", 32'(idx), 32'd4);
    repeat (2) @(negedge clk);
    chk("bp_no_dup", 32'(out_valid), 32'd0);

    // Reset with a result in flight: it must never appear
    drive(vecs[0]);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("midrst_no_out_c%0d", c), 32'(out_valid), 32'd0);
      @(negedge clk);
    end
    chk("midrst_sticky", 32'(sticky_flags), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
